// File: rtl/fuq_wb_stage.sv
// Writeback stage: buffers FU results in a small FIFO, drains them to the PRF
// under a write grant, and merges the local writeback into the wakeup vector.
module fuq_wb_stage #(
   parameter int INST_ID_BITS = 6,
   parameter int PRN_BITS     = 6,
   parameter int MAX_OPERANDS = 3,
   parameter int FU_COUNT     = 4,
   parameter int FU_INDEX     = 2,
   parameter int WB_DEPTH     = 2
) (
   input  logic                                               clk,
   input  logic                                               rst,
   input  logic                                               flush,
   input  logic                                               fu_out_valid,
   input  logic [INST_ID_BITS-1:0]                            fu_out_inst_id,
   input  logic [MAX_OPERANDS-1:0][63:0]                      fu_out_data,
   input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              fu_out_prn,
   input  logic [MAX_OPERANDS-1:0]                            fu_out_prn_valid,
   output logic                                               fu_stall,
   input  logic                                               wb_grant,
   output logic [MAX_OPERANDS-1:0][63:0]                      prf_write,
   output logic [MAX_OPERANDS-1:0]                            prf_write_enable,
   output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]              prf_write_prn,
   output logic                                               done_valid,
   output logic [INST_ID_BITS-1:0]                            done_inst_id,
   input  logic [FU_COUNT-2:0][MAX_OPERANDS-1:0]              set_prn_ready,
   input  logic [FU_COUNT-2:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] set_prn,
   output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]              full_set_prn_ready,
   output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] full_set_prn,
   output logic [$clog2(WB_DEPTH+1)-1:0]                      occupancy,
   output logic [15:0]                                        stall_cycles
);
   localparam int CW = $clog2(WB_DEPTH+1);
   localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;

   typedef struct packed {
      logic [INST_ID_BITS-1:0]               inst_id;
      logic [MAX_OPERANDS-1:0][63:0]         data;
      logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
      logic [MAX_OPERANDS-1:0]               prn_valid;
   } wb_entry_t;

   wb_entry_t     ent_q [WB_DEPTH];
   wb_entry_t     head;
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          push, pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(WB_DEPTH-1)) ? '0 : p + PW'(1);
   endfunction

   assign fu_stall = (count == CW'(WB_DEPTH));
   assign push     = fu_out_valid & ~fu_stall & ~flush;
   assign pop      = (count != '0) & wb_grant & ~flush;
   assign head     = ent_q[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count        <= '0;
         rd_ptr       <= '0;
         wr_ptr       <= '0;
         stall_cycles <= '0;
         for (int i = 0; i < WB_DEPTH; i++) ent_q[i] <= '0;
      end else begin
         if (push) ent_q[wr_ptr] <= {fu_out_inst_id, fu_out_data, fu_out_prn, fu_out_prn_valid};
         if (flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
         end
         if (fu_out_valid && fu_stall && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

   assign prf_write        = head.data;
   assign prf_write_prn    = head.prn;
   assign prf_write_enable = {MAX_OPERANDS{pop}} & head.prn_valid;
   assign done_valid       = pop;
   assign done_inst_id     = head.inst_id;
   assign occupancy        = count;

   // Local slot is driven by the PRF write itself, so wakeup coincides with the write.
   for (genvar g = 0; g < FU_COUNT; g++) begin : g_wake
      if (g == FU_INDEX) begin : g_local
         assign full_set_prn_ready[g] = prf_write_enable;
         assign full_set_prn[g]       = prf_write_prn;
      end else if (g < FU_INDEX) begin : g_lo
         assign full_set_prn_ready[g] = set_prn_ready[g];
         assign full_set_prn[g]       = set_prn[g];
      end else begin : g_hi
         assign full_set_prn_ready[g] = set_prn_ready[g-1];
         assign full_set_prn[g]       = set_prn[g-1];
      end
   end
endmodule

// File: tb/tb_fuq_wb_stage.sv
// Directed bench for fuq_wb_stage: a depth-2 and a depth-3 instance share data
// inputs; each has its own valid/grant so they can be exercised independently.
module tb_fuq_wb_stage;
   logic clk = 0, rst = 1, flush = 0;
   logic valid2 = 0, valid3 = 0, grant2 = 0, grant3 = 0;
   logic [5:0]       fu_out_inst_id = '0;
   logic [2:0][63:0] fu_out_data = '0;
   logic [2:0][5:0]  fu_out_prn = '0;
   logic [2:0]       fu_out_prn_valid = '0;
   logic [2:0][2:0]      set_prn_ready = '0;
   logic [2:0][2:0][5:0] set_prn = '0;

   logic stall2, stall3, dv2, dv3;
   logic [2:0][63:0] pw2, pw3;
   logic [2:0] pwe2, pwe3;
   logic [2:0][5:0] pwp2, pwp3;
   logic [5:0] did2, did3;
   logic [3:0][2:0] fr2, fr3;
   logic [3:0][2:0][5:0] fp2, fp3;
   logic [1:0] occ2, occ3;
   logic [15:0] sc2, sc3;

   int passed = 0, total = 0;

   always #5 clk = ~clk;

   fuq_wb_stage #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .FU_COUNT(4), .FU_INDEX(2), .WB_DEPTH(2)) dut2 (
      .clk(clk), .rst(rst), .flush(flush), .fu_out_valid(valid2), .fu_out_inst_id(fu_out_inst_id),
      .fu_out_data(fu_out_data), .fu_out_prn(fu_out_prn), .fu_out_prn_valid(fu_out_prn_valid),
      .fu_stall(stall2), .wb_grant(grant2), .prf_write(pw2), .prf_write_enable(pwe2), .prf_write_prn(pwp2),
      .done_valid(dv2), .done_inst_id(did2), .set_prn_ready(set_prn_ready), .set_prn(set_prn),
      .full_set_prn_ready(fr2), .full_set_prn(fp2), .occupancy(occ2), .stall_cycles(sc2));

   fuq_wb_stage #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .FU_COUNT(4), .FU_INDEX(2), .WB_DEPTH(3)) dut3 (
      .clk(clk), .rst(rst), .flush(flush), .fu_out_valid(valid3), .fu_out_inst_id(fu_out_inst_id),
      .fu_out_data(fu_out_data), .fu_out_prn(fu_out_prn), .fu_out_prn_valid(fu_out_prn_valid),
      .fu_stall(stall3), .wb_grant(grant3), .prf_write(pw3), .prf_write_enable(pwe3), .prf_write_prn(pwp3),
      .done_valid(dv3), .done_inst_id(did3), .set_prn_ready(set_prn_ready), .set_prn(set_prn),
      .full_set_prn_ready(fr3), .full_set_prn(fp3), .occupancy(occ3), .stall_cycles(sc3));

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic test_reset;
      #2;
      total++; if (occ2 !== 2'd0) $display("FAIL reset_occ: got %0d exp 0", occ2); else passed++;
      total++; if (stall2 !== 1'b0) $display("FAIL reset_stall: got %0b exp 0", stall2); else passed++;
      total++; if (dv2 !== 1'b0 || pwe2 !== 3'b0) $display("FAIL reset_strobes: got dv=%0b en=%0b exp 0", dv2, pwe2); else passed++;
      total++; if (pw2 !== '0 || pwp2 !== '0 || did2 !== 6'd0) $display("FAIL reset_head: got id=%0h exp 0", did2); else passed++;
      total++; if (sc2 !== 16'd0) $display("FAIL reset_sc: got %0d exp 0", sc2); else passed++;
      step; rst = 0;
   endtask

   task automatic test_single;
      grant2 = 1; valid2 = 1; fu_out_inst_id = 6'd5; fu_out_prn = '0; fu_out_prn[0] = 6'd7;
      fu_out_data = '0; fu_out_data[0] = 64'hAB; fu_out_prn_valid = 3'b001;
      #1;
      total++; if (dv2 !== 1'b0) $display("FAIL single_nobypass: got dv=%0b exp 0", dv2); else passed++;
      step; valid2 = 0;
      total++; if (dv2 !== 1'b1 || did2 !== 6'd5) $display("FAIL single_done: got dv=%0b id=%0d exp 1/5", dv2, did2); else passed++;
      total++; if (pwe2 !== 3'b001 || pwp2[0] !== 6'd7) $display("FAIL single_write: got en=%0b prn=%0d exp 001/7", pwe2, pwp2[0]); else passed++;
      total++; if (pw2[0] !== 64'hAB) $display("FAIL single_data: got %0h exp ab", pw2[0]); else passed++;
      total++; if (fr2[2] !== 3'b001 || fp2[2][0] !== 6'd7) $display("FAIL single_wake: got rdy=%0b prn=%0d exp 001/7", fr2[2], fp2[2][0]); else passed++;
      step;
      total++; if (occ2 !== 2'd0 || dv2 !== 1'b0) $display("FAIL single_drained: got occ=%0d dv=%0b exp 0/0", occ2, dv2); else passed++;
      grant2 = 0;
   endtask

   task automatic test_stall;
      valid2 = 1; fu_out_inst_id = 6'd1; fu_out_prn_valid = 3'b001;
      step; fu_out_inst_id = 6'd2;
      total++; if (occ2 !== 2'd1 || stall2 !== 1'b0) $display("FAIL stall_one: got occ=%0d st=%0b exp 1/0", occ2, stall2); else passed++;
      step; fu_out_inst_id = 6'd3;
      total++; if (stall2 !== 1'b1 || occ2 !== 2'd2) $display("FAIL stall_full: got st=%0b occ=%0d exp 1/2", stall2, occ2); else passed++;
      total++; if (sc2 !== 16'd0) $display("FAIL stall_cnt0: got %0d exp 0", sc2); else passed++;
      step;
      total++; if (sc2 !== 16'd1 || occ2 !== 2'd2) $display("FAIL stall_cnt1: got sc=%0d occ=%0d exp 1/2", sc2, occ2); else passed++;
      step; grant2 = 1; #1;
      total++; if (sc2 !== 16'd2) $display("FAIL stall_cnt2: got %0d exp 2", sc2); else passed++;
      total++; if (dv2 !== 1'b1 || did2 !== 6'd1) $display("FAIL stall_drain1: got dv=%0b id=%0d exp 1/1", dv2, did2); else passed++;
      step;
      total++; if (sc2 !== 16'd3) $display("FAIL stall_cnt3: got %0d exp 3", sc2); else passed++;
      total++; if (dv2 !== 1'b1 || did2 !== 6'd2) $display("FAIL stall_drain2: got dv=%0b id=%0d exp 1/2", dv2, did2); else passed++;
      step; valid2 = 0;
      total++; if (dv2 !== 1'b1 || did2 !== 6'd3) $display("FAIL stall_drain3: got dv=%0b id=%0d exp 1/3", dv2, did2); else passed++;
      step; grant2 = 0;
      total++; if (occ2 !== 2'd0 || sc2 !== 16'd3) $display("FAIL stall_end: got occ=%0d sc=%0d exp 0/3", occ2, sc2); else passed++;
   endtask

   task automatic test_wrap;
      int exp_q[$];
      int nxt = 0, got = 0, max_occ = 0;
      for (int cyc = 0; cyc < 60 && got < 7; cyc++) begin
         grant3 = (cyc % 2 == 0);
         valid3 = (nxt < 7);
         fu_out_inst_id = 6'(10 + nxt);
         fu_out_data[0] = 64'(100 + nxt);
         fu_out_prn_valid = 3'b001;
         #1;
         if (int'(occ3) > max_occ) max_occ = int'(occ3);
         if (dv3) begin
            total++;
            if (exp_q.size() == 0 || did3 !== 6'(exp_q[0]) || pw3[0] !== 64'(exp_q[0] + 90))
               $display("FAIL wrap_order: got id=%0d data=%0d exp id=%0d", did3, pw3[0], (exp_q.size() != 0) ? exp_q[0] : -1);
            else passed++;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            got++;
         end
         if (valid3 && !stall3) begin exp_q.push_back(10 + nxt); nxt++; end
         step;
      end
      valid3 = 0; grant3 = 0;
      total++; if (got !== 7) $display("FAIL wrap_count: got %0d exp 7", got); else passed++;
      total++; if (max_occ !== 3) $display("FAIL wrap_maxocc: got %0d exp 3", max_occ); else passed++;
   endtask

   task automatic test_flush;
      valid2 = 1; fu_out_inst_id = 6'd20; fu_out_prn_valid = 3'b011;
      step; fu_out_inst_id = 6'd21;
      step; fu_out_inst_id = 6'd22; flush = 1; grant2 = 1; #1;
      total++; if (occ2 !== 2'd2) $display("FAIL flush_pre: got occ=%0d exp 2", occ2); else passed++;
      total++; if (dv2 !== 1'b0 || pwe2 !== 3'b0) $display("FAIL flush_strobe: got dv=%0b en=%0b exp 0/0", dv2, pwe2); else passed++;
      step; flush = 0; valid2 = 0; #1;
      total++; if (occ2 !== 2'd0 || dv2 !== 1'b0) $display("FAIL flush_empty: got occ=%0d dv=%0b exp 0/0", occ2, dv2); else passed++;
      valid2 = 1; fu_out_inst_id = 6'd23;
      step; valid2 = 0;
      total++; if (dv2 !== 1'b1 || did2 !== 6'd23) $display("FAIL flush_after: got dv=%0b id=%0d exp 1/23", dv2, did2); else passed++;
      step; grant2 = 0;
   endtask

   task automatic test_wakeup;
      set_prn_ready[0] = 3'b100; set_prn[0][2] = 6'd11;
      set_prn_ready[1] = 3'b001; set_prn[1][0] = 6'd12;
      set_prn_ready[2] = 3'b010; set_prn[2][1] = 6'd9;
      #1;
      total++; if (fr2[3] !== 3'b010 || fp2[3][1] !== 6'd9) $display("FAIL wake_hi: got rdy=%0b prn=%0d exp 010/9", fr2[3], fp2[3][1]); else passed++;
      total++; if (fr2[0] !== 3'b100 || fp2[0][2] !== 6'd11 || fr2[1] !== 3'b001 || fp2[1][0] !== 6'd12)
         $display("FAIL wake_lo: got rdy0=%0b rdy1=%0b exp 100/001", fr2[0], fr2[1]); else passed++;
      total++; if (fr2[2] !== 3'b000) $display("FAIL wake_idle: got %0b exp 000", fr2[2]); else passed++;
      valid2 = 1; grant2 = 1; fu_out_inst_id = 6'd40; fu_out_prn_valid = 3'b010; fu_out_prn[1] = 6'd4;
      step; valid2 = 0;
      total++; if (fr2[2] !== 3'b010 || fp2[2][1] !== 6'd4 || fp2[3][1] !== 6'd9)
         $display("FAIL wake_local: got rdy=%0b prn=%0d hi=%0d exp 010/4/9", fr2[2], fp2[2][1], fp2[3][1]); else passed++;
      step; grant2 = 0;
   endtask

   task automatic test_async_reset;
      valid2 = 1; fu_out_inst_id = 6'd30; fu_out_prn_valid = 3'b111; fu_out_prn = {6'd3, 6'd2, 6'd1};
      fu_out_data = {64'h3, 64'h2, 64'h1};
      step; fu_out_inst_id = 6'd31;
      step; valid2 = 0; grant2 = 1; #1;
      total++; if (occ2 !== 2'd2 || dv2 !== 1'b1) $display("FAIL areset_pre: got occ=%0d dv=%0b exp 2/1", occ2, dv2); else passed++;
      rst = 1; #1;
      total++; if (occ2 !== 2'd0 || dv2 !== 1'b0 || pwe2 !== 3'b0) $display("FAIL areset_occ: got occ=%0d dv=%0b exp 0/0", occ2, dv2); else passed++;
      total++; if (pw2 !== '0 || pwp2 !== '0 || did2 !== 6'd0) $display("FAIL areset_head: got id=%0d exp 0", did2); else passed++;
      total++; if (sc2 !== 16'd0 || sc3 !== 16'd0) $display("FAIL areset_sc: got %0d/%0d exp 0", sc2, sc3); else passed++;
      step; rst = 0; grant2 = 0;
   endtask

   initial begin
      test_reset;
      test_single;
      test_stall;
      test_wrap;
      test_flush;
      test_wakeup;
      test_async_reset;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
